// File: rtl/parking_gate_sequencer.sv
// parking_gate_sequencer: entry/exit barrier sequencing and per-car event pulses; GATE_STATS_EN adds denial/timeout counters
module parking_gate_sequencer #(
  parameter int OPEN_TIMEOUT = 30,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_detect,
  input  logic       entry_is_uni,
  input  logic       entry_pass,
  input  logic       exit_detect,
  input  logic       exit_is_uni,
  input  logic       exit_pass,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
`ifdef GATE_STATS_EN
  output logic [15:0] denied_count,
  output logic [15:0] timeout_count,
`endif
  output logic       entry_barrier_open,
  output logic       exit_barrier_open,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_denied,
  output logic [1:0] gate_timeout
);
  typedef enum logic [2:0] {E_IDLE, E_CHECK, E_OPEN, E_PASS, E_DENY, E_REARM} ent_t;
  typedef enum logic [1:0] {X_IDLE, X_OPEN, X_PASS, X_REARM} ext_t;
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(OPEN_TIMEOUT - 1);
  ent_t ent_q, ent_d;
  ext_t ext_q, ext_d;
  logic ecls_q, ecls_d, xcls_q, xcls_d;
  logic [CNT_W-1:0] etmr_q, etmr_d, xtmr_q, xtmr_d;
  logic [1:0] ep_q, xp_q;
  logic e_rise, e_fall, x_rise, x_fall;
  logic e_open, e_ev, e_den, e_to, x_open, x_ev, x_to;
  // pass sensors go through two stages so edges appear one cycle after the sensor moves
  assign e_rise = ep_q[0] & ~ep_q[1];
  assign e_fall = ~ep_q[0] & ep_q[1];
  assign x_rise = xp_q[0] & ~xp_q[1];
  assign x_fall = ~xp_q[0] & xp_q[1];
  // state, latched badge class, open timers and sensor history
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q  <= E_IDLE;
      ext_q  <= X_IDLE;
      ecls_q <= 1'b0;
      xcls_q <= 1'b0;
      etmr_q <= '0;
      xtmr_q <= '0;
      ep_q   <= '0;
      xp_q   <= '0;
    end else begin
      ent_q  <= ent_d;
      ext_q  <= ext_d;
      ecls_q <= ecls_d;
      xcls_q <= xcls_d;
      etmr_q <= etmr_d;
      xtmr_q <= xtmr_d;
      ep_q   <= {ep_q[0], entry_pass};
      xp_q   <= {xp_q[0], exit_pass};
    end
  end
  // entry gate: badge latch, vacancy check, open/pass/timeout sequencing
  always_comb begin
    ent_d  = ent_q;
    ecls_d = ecls_q;
    etmr_d = etmr_q;
    e_open = 1'b0;
    e_ev   = 1'b0;
    e_den  = 1'b0;
    e_to   = 1'b0;
    case (ent_q)
      E_IDLE: if (entry_detect) begin
        ecls_d = entry_is_uni;
        ent_d  = E_CHECK;
      end
      E_CHECK: if (ecls_q ? uni_is_vacated_space : is_vacated_space) begin
        ent_d  = E_OPEN;
        etmr_d = '0;
      end else begin
        e_den = 1'b1;
        ent_d = E_DENY;
      end
      E_OPEN: begin
        e_open = 1'b1;
        etmr_d = etmr_q + CNT_W'(1);
        if (e_rise) ent_d = E_PASS;
        else if (etmr_q == TMR_LAST) begin
          e_to  = 1'b1;
          ent_d = E_REARM;
        end
      end
      E_PASS: if (e_fall) begin
        e_ev  = 1'b1;
        ent_d = E_REARM;
      end else e_open = 1'b1;
      default: if (!entry_detect) ent_d = E_IDLE;
    endcase
  end
  // exit gate: same sequencing without the vacancy check
  always_comb begin
    ext_d  = ext_q;
    xcls_d = xcls_q;
    xtmr_d = xtmr_q;
    x_open = 1'b0;
    x_ev   = 1'b0;
    x_to   = 1'b0;
    case (ext_q)
      X_IDLE: if (exit_detect) begin
        xcls_d = exit_is_uni;
        xtmr_d = '0;
        ext_d  = X_OPEN;
      end
      X_OPEN: begin
        x_open = 1'b1;
        xtmr_d = xtmr_q + CNT_W'(1);
        if (x_rise) ext_d = X_PASS;
        else if (xtmr_q == TMR_LAST) begin
          x_to  = 1'b1;
          ext_d = X_REARM;
        end
      end
      X_PASS: if (x_fall) begin
        x_ev  = 1'b1;
        ext_d = X_REARM;
      end else x_open = 1'b1;
      default: if (!exit_detect) ext_d = X_IDLE;
    endcase
  end
  assign entry_barrier_open = e_open & ~rst;
  assign exit_barrier_open  = x_open & ~rst;
  assign car_entered        = e_ev & ~rst;
  assign is_uni_car_entered = e_ev & ecls_q & ~rst;
  assign car_exited         = x_ev & ~rst;
  assign is_uni_car_exited  = x_ev & xcls_q & ~rst;
  assign entry_denied       = e_den & ~rst;
  assign gate_timeout       = {x_to, e_to} & {2{~rst}};
`ifdef GATE_STATS_EN
  logic [15:0] dcnt_q, tcnt_q;
  logic [16:0] tsum;
  assign tsum = {1'b0, tcnt_q} + 17'(gate_timeout[0]) + 17'(gate_timeout[1]);
  // saturating denial and abort counters
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      dcnt_q <= (entry_denied && dcnt_q != 16'hFFFF) ? dcnt_q + 16'd1 : dcnt_q;
      tcnt_q <= tsum[16] ? 16'hFFFF : tsum[15:0];
    end
  end
  assign denied_count  = rst ? '0 : dcnt_q;
  assign timeout_count = rst ? '0 : tcnt_q;
`endif
endmodule
